// File: rtl/mips_multicycle_ctrl.sv
// Moore main-control FSM for the 8-bit multicycle mini-MIPS datapath.
// Defining MIPS_CTRL_BNE_EN adds the BNE opcode (000101) and its BNEEX state.
module mips_multicycle_ctrl #(
    parameter int unsigned FETCH_BYTES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg
);
    localparam int unsigned NFETCH = (FETCH_BYTES < 1) ? 1 : ((FETCH_BYTES > 4) ? 4 : FETCH_BYTES);

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam int unsigned STATE_W = 5;
`else
    localparam int unsigned STATE_W = 4;
`endif

    typedef enum logic [STATE_W-1:0] {
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_FETCH4,
        S_DECODE,
        S_MEMADR,
        S_LBRD,
        S_LBWR,
        S_SBWR,
        S_RTYPEEX,
        S_RTYPEWR,
        S_BEQEX,
        S_JEX,
        S_ADDIEX,
`ifdef MIPS_CTRL_BNE_EN
        S_ADDIWR,
        S_BNEEX
`else
        S_ADDIWR
`endif
    } state_t;

    // Control word held in flops; enables are gated by reset at the port.
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       iord;
        logic [3:0] irwrite;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
    } ctrl_t;

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;
    logic   w_take;

    function automatic state_t next_state(input state_t s, input logic [5:0] o);
        next_state = S_FETCH1;
        case (s)
            S_FETCH1:  next_state = (NFETCH > 1) ? S_FETCH2 : S_DECODE;
            S_FETCH2:  next_state = (NFETCH > 2) ? S_FETCH3 : S_DECODE;
            S_FETCH3:  next_state = (NFETCH > 3) ? S_FETCH4 : S_DECODE;
            S_FETCH4:  next_state = S_DECODE;
            S_DECODE: begin
                case (o)
                    OP_LB, OP_SB: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_J:         next_state = S_JEX;
                    OP_ADDI:      next_state = S_ADDIEX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       next_state = S_BNEEX;
`endif
                    default:      next_state = S_FETCH1;
                endcase
            end
            S_MEMADR: begin
                if (o == OP_LB)
                    next_state = S_LBRD;
                else if (o == OP_SB)
                    next_state = S_SBWR;
                else
                    next_state = S_FETCH1;
            end
            S_LBRD:    next_state = S_LBWR;
            S_RTYPEEX: next_state = S_RTYPEWR;
            S_ADDIEX:  next_state = S_ADDIWR;
            // Terminal states and any unused encoding restart the fetch.
            default:   next_state = S_FETCH1;
        endcase
    endfunction

    function automatic ctrl_t decode(input state_t s);
        decode = '0;
        case (s)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                decode.memread = 1'b1;
                decode.alusrcb = 2'b01;
                decode.pcwrite = 1'b1;
                case (s)
                    S_FETCH1: decode.irwrite = 4'b0001;
                    S_FETCH2: decode.irwrite = 4'b0010;
                    S_FETCH3: decode.irwrite = 4'b0100;
                    default:  decode.irwrite = 4'b1000;
                endcase
            end
            S_DECODE: decode.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                decode.alusrca = 1'b1;
                decode.alusrcb = 2'b10;
            end
            S_LBRD: begin
                decode.memread = 1'b1;
                decode.iord    = 1'b1;
            end
            S_LBWR: begin
                decode.regwrite = 1'b1;
                decode.memtoreg = 1'b1;
            end
            S_SBWR: begin
                decode.memwrite = 1'b1;
                decode.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                decode.alusrca = 1'b1;
                decode.aluop   = 2'b10;
            end
            S_RTYPEWR: begin
                decode.regwrite = 1'b1;
                decode.regdst   = 1'b1;
            end
            S_BEQEX: begin
                decode.alusrca = 1'b1;
                decode.aluop   = 2'b01;
                decode.branch  = 1'b1;
                decode.pcsrc   = 2'b01;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNEEX: begin
                decode.alusrca = 1'b1;
                decode.aluop   = 2'b01;
                decode.branch  = 1'b1;
                decode.bne     = 1'b1;
                decode.pcsrc   = 2'b01;
            end
`endif
            S_JEX: begin
                decode.pcwrite = 1'b1;
                decode.pcsrc   = 2'b10;
            end
            S_ADDIWR: decode.regwrite = 1'b1;
            default: ;
        endcase
    endfunction

    assign w_next = next_state(r_state, op);

    // Control flops are loaded with the decode of the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH1;
            r_ctrl  <= decode(S_FETCH1);
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode(w_next);
        end
    end

    // Branch condition is evaluated on the live zero flag of the branch cycle.
    assign w_take = r_ctrl.branch & (zero ^ r_ctrl.bne);

    assign memread  = reset & r_ctrl.memread;
    assign memwrite = reset & r_ctrl.memwrite;
    assign regwrite = reset & r_ctrl.regwrite;
    assign irwrite  = {4{reset}} & r_ctrl.irwrite;
    assign pcen     = reset & (r_ctrl.pcwrite | w_take);
    assign alusrca  = r_ctrl.alusrca;
    assign alusrcb  = r_ctrl.alusrcb;
    assign aluop    = r_ctrl.aluop;
    assign iord     = r_ctrl.iord;
    assign pcsrc    = r_ctrl.pcsrc;
    assign regdst   = r_ctrl.regdst;
    assign memtoreg = r_ctrl.memtoreg;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the 8-bit multicycle mini-MIPS datapath.
- Sequences byte-wise instruction fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects, write enables and the 2-bit aluop consumed by the ALU-control decoder.
- Sits beside the datapath. Inputs are the IR opcode field and the ALU zero flag.

Parameters:
- FETCH_BYTES, 4, number of fetch states (legal 1..4). Fetch state k asserts irwrite bit k-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- op  input  6  opcode, IR[31:26].
- zero  input  1  ALU zero flag.
- memread  output  1  memory read enable.
- memwrite  output  1  memory write enable.
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B select: 00 = reg B, 01 = constant 1, 10 = imm, 11 = imm (branch offset).
- aluop  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- iord  output  1  address select: 0 = PC, 1 = ALUOut.
- irwrite  output  4  per-byte IR load enables.
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  output  1  PC write enable.
- regwrite  output  1  register file write enable.
- regdst  output  1  write register select: 0 = rt, 1 = rd.
- memtoreg  output  1  writeback data select: 0 = ALUOut, 1 = MDR.

Behaviour:
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, J 000010, ADDI 001000.
- Outputs are a pure function of the state register, except pcen = pcwrite | (branch & zero).
- Default value of every output in every state is 0.
- Reset: on a clk edge with reset==0, state <= FETCH1. While reset==0, all enables (memread, memwrite, irwrite, pcen, regwrite) are forced to 0, regardless of state. A reset asserted mid-instruction aborts it with no further writes.
- FETCH1..FETCH_BYTES: memread=1, alusrcb=01, aluop=00, pcwrite=1, irwrite=one-hot bit k-1. Each state advances to the next. The last one goes to DECODE.
- DECODE: alusrcb=11, aluop=00 (branch target into ALUOut).
  - LB/SB -> MEMADR
  - RTYPE -> RTYPEEX
  - BEQ -> BEQEX
  - J -> JEX
  - ADDI -> ADDIEX
  - any other opcode -> FETCH1, with no writes (illegal opcode is a NOP).
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LB -> LBRD; SB -> SBWR.
- LBRD: memread=1, iord=1 -> LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0 -> FETCH1.
- SBWR: memwrite=1, iord=1 -> FETCH1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1, memtoreg=0 -> FETCH1.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01 -> FETCH1. pcen follows zero in that same cycle.
- JEX: pcwrite=1, pcsrc=10 -> FETCH1.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWR.
- ADDIWR: regwrite=1, regdst=0, memtoreg=0 -> FETCH1.
- Cycles per instruction, counted from FETCH1 entry to the next FETCH1 with FETCH_BYTES=4:
  - LB 8
  - SB, RTYPE, ADDI 7
  - BEQ, J 6
- op is sampled only in DECODE and MEMADR; changes to op in other states are ignored.
- zero is used only in BEQEX.
- State register is 4 bits (5 with the optional feature); unreachable encodings return to FETCH1 on the next edge.
- Exactly one of memread/memwrite is high in any cycle, or neither. regwrite and memwrite are never high together.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined: opcode 000101 (BNE) decodes in DECODE to state BNEEX. BNEEX drives the same outputs as BEQEX, but pcen = pcwrite | (branch & ~zero). BNE takes 6 cycles.
- Undefined: 000101 is treated as illegal (DECODE -> FETCH1, no writes). The BNEEX state does not exist.

Test Plan:
- Reset: hold reset=0 for 3 cycles with op=101000 -> all enables 0 throughout. On the first cycle after release, memread=1, irwrite=0001, pcen=1. Three more cycles give irwrite 0010, 0100, 1000.
- LB: op=100000 -> sequence FETCH1-4, DECODE, MEMADR (alusrca=1, alusrcb=10), LBRD (memread=1, iord=1), LBWR (regwrite=1, memtoreg=1). Total 8 cycles, then FETCH1.
- RTYPE then ADDI back-to-back -> RTYPEEX aluop=10, RTYPEWR regdst=1; ADDIWR regdst=0, memtoreg=0. 7 cycles each.
- BEQ with zero=1 -> pcen=1 and pcsrc=01 in BEQEX. Repeat with zero=0 -> pcen=0 in BEQEX. Both take 6 cycles.
- Illegal op=111111 -> DECODE returns to FETCH1 with no memwrite/regwrite pulse. J (op=000010) -> JEX with pcsrc=10, pcen=1.
- Reset dropped to 0 during SBWR -> memwrite deasserts in the same cycle. After release, the FSM restarts at FETCH1. With MIPS_CTRL_BNE_EN defined and op=000101, zero=0 -> pcen=1 in BNEEX.
